// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for nn_seq_mlp2.
// Defining NN_SAT_EN makes requant saturate; without it, requant wraps.
package nn_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_L1   = 2'd1;
    localparam logic [1:0] S_L2   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        L1   = S_L1,
        L2   = S_L2,
        DONE = S_DONE
    } state_t;

    // Wide working width for requant/relu so one function serves any WIDTH/ACC_W.
    localparam int unsigned RQ_W = 128;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned width, input int unsigned n_a,
                                          input int unsigned n_b);
        return 2 * width + $clog2(max_u(n_a, n_b)) + 1;
    endfunction

    function automatic logic signed [RQ_W-1:0] requant(input logic signed [RQ_W-1:0] acc,
                                                       input int unsigned width,
                                                       input int unsigned frac);
        logic signed [RQ_W-1:0] sh;
        logic signed [RQ_W-1:0] one;
        logic signed [RQ_W-1:0] hi;
        logic signed [RQ_W-1:0] lo;
        sh  = acc >>> frac;
        one = 1;
        hi  = (one <<< (width - 1)) - one;
        lo  = ~hi;
`ifdef NN_SAT_EN
        if (sh > hi) return hi;
        if (sh < lo) return lo;
        return sh;
`else
        // Keep the low width bits, re-sign-extended so the caller's cast is exact.
        return (sh <<< (RQ_W - width)) >>> (RQ_W - width);
`endif
    endfunction

    function automatic logic signed [RQ_W-1:0] relu(input logic signed [RQ_W-1:0] v);
        return v[RQ_W-1] ? '0 : v;
    endfunction

endpackage

// File: rtl/nn_seq_mlp2_if.sv
// Handshake, weight-write and result bundle for nn_seq_mlp2.
interface nn_seq_mlp2_if
    import nn_pkg::*;
#(
    parameter int unsigned IN_SIZE  = 4,
    parameter int unsigned HIDDEN1  = 3,
    parameter int unsigned OUT_SIZE = 2,
    parameter int unsigned WIDTH    = 16
);
    localparam int unsigned AW    = idx_w(max_u(HIDDEN1 * IN_SIZE, OUT_SIZE * HIDDEN1));
    localparam int unsigned CLS_W = $clog2(OUT_SIZE);

    logic                              wr_en;
    logic                              wr_layer;
    logic [AW-1:0]                     wr_addr;
    logic signed [WIDTH-1:0]           wr_data;
    logic                              in_valid;
    logic                              in_ready;
    logic [IN_SIZE-1:0][WIDTH-1:0]     in_vec;
    logic                              out_valid;
    logic                              out_ready;
    logic [OUT_SIZE-1:0][WIDTH-1:0]    out_vec;
    logic [CLS_W-1:0]                  out_class;
    logic                              busy;

    modport master (
        output wr_en, wr_layer, wr_addr, wr_data, in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_vec, out_class, busy
    );

    modport slave (
        input  wr_en, wr_layer, wr_addr, wr_data, in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_vec, out_class, busy
    );

endinterface

// File: rtl/nn_mac.sv
// Shared multiply-accumulate: q is the requantised value of acc + a*b, i.e. the
// row result including the product issued in the current cycle.
module nn_mac
    import nn_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned FRAC  = 12,
    parameter int unsigned ACC_W = 35
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] q
);
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   sum;
    logic signed [2*WIDTH-1:0] prod;

    assign prod = a * b;
    assign sum  = acc + ACC_W'(prod);
    assign q    = WIDTH'(requant(RQ_W'(sum), WIDTH, FRAC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= sum;
    end

endmodule

// File: rtl/nn_seq_mlp2.sv
// nn_seq_mlp2: two dense layers (ReLU between) evaluated on one time-shared MAC,
// with argmax over the logits. NN_SAT_EN selects saturating requantisation.
module nn_seq_mlp2
    import nn_pkg::*;
#(
    parameter int unsigned IN_SIZE  = 4,
    parameter int unsigned HIDDEN1  = 3,
    parameter int unsigned OUT_SIZE = 2,
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned FRAC     = 12
) (
    input  logic         clk,
    input  logic         rst,
    nn_seq_mlp2_if.slave bus
);
    localparam int unsigned N1    = HIDDEN1 * IN_SIZE;
    localparam int unsigned N2    = OUT_SIZE * HIDDEN1;
    localparam int unsigned ACC_W = acc_w(WIDTH, IN_SIZE, HIDDEN1);
    localparam int unsigned AW    = idx_w(max_u(N1, N2));
    localparam int unsigned A1W   = idx_w(N1);
    localparam int unsigned A2W   = idx_w(N2);
    localparam int unsigned XW    = idx_w(IN_SIZE);
    localparam int unsigned HW    = idx_w(HIDDEN1);
    localparam int unsigned OW    = idx_w(OUT_SIZE);
    localparam int unsigned CW    = idx_w(max_u(IN_SIZE, HIDDEN1));
    localparam int unsigned RW    = idx_w(max_u(HIDDEN1, OUT_SIZE));
    localparam int unsigned CLS_W = $clog2(OUT_SIZE);

    localparam logic [CW-1:0] C1_LAST = CW'(IN_SIZE - 1);
    localparam logic [CW-1:0] C2_LAST = CW'(HIDDEN1 - 1);
    localparam logic [RW-1:0] R1_LAST = RW'(HIDDEN1 - 1);
    localparam logic [RW-1:0] R2_LAST = RW'(OUT_SIZE - 1);

    state_t                  state;
    logic [RW-1:0]           r;
    logic [CW-1:0]           c;
    logic signed [WIDTH-1:0] x   [IN_SIZE];
    logic signed [WIDTH-1:0] w1  [N1];
    logic signed [WIDTH-1:0] w2  [N2];
    logic signed [WIDTH-1:0] hid [HIDDEN1];
    logic signed [WIDTH-1:0] ov  [OUT_SIZE];
    logic signed [WIDTH-1:0] vmax;
    logic [CLS_W-1:0]        cls;

    logic                    pend;
    logic                    pend_layer;
    logic [AW-1:0]           pend_addr;
    logic signed [WIDTH-1:0] pend_old;

    logic                    accept;
    logic                    mac_busy;
    logic                    row_end;
    logic                    wr_ok;
    logic [A1W-1:0]          i1;
    logic [A2W-1:0]          i2;
    logic signed [WIDTH-1:0] mac_a;
    logic signed [WIDTH-1:0] mac_b;
    logic signed [WIDTH-1:0] mac_q;

    assign accept   = (state == IDLE) && bus.in_valid;
    assign mac_busy = (state == L1) || (state == L2);
    assign row_end  = ((state == L1) && (c == C1_LAST)) || ((state == L2) && (c == C2_LAST));
    assign wr_ok    = bus.wr_en && ((state == IDLE) || (state == DONE)) &&
                      (bus.wr_layer ? (32'(bus.wr_addr) < N2) : (32'(bus.wr_addr) < N1));
    assign i1       = A1W'(32'(r) * IN_SIZE + 32'(c));
    assign i2       = A2W'(32'(r) * HIDDEN1 + 32'(c));

    // A write landing on the accept edge is applied at once, but its pre-write
    // value is kept aside and substituted at that address for this inference.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        if (state == L2) begin
            mac_a = w2[i2];
            mac_b = hid[HW'(c)];
            if (pend && pend_layer && (32'(pend_addr) == 32'(i2))) mac_a = pend_old;
        end else begin
            mac_a = w1[i1];
            mac_b = x[XW'(c)];
            if (pend && !pend_layer && (32'(pend_addr) == 32'(i1))) mac_a = pend_old;
        end
    end

    nn_mac #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (accept || row_end),
        .en  (mac_busy),
        .a   (mac_a),
        .b   (mac_b),
        .q   (mac_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            r          <= '0;
            c          <= '0;
            vmax       <= '0;
            cls        <= '0;
            pend       <= 1'b0;
            pend_layer <= 1'b0;
            pend_addr  <= '0;
            pend_old   <= '0;
            for (int unsigned i = 0; i < IN_SIZE; i++)  x[XW'(i)]   <= '0;
            for (int unsigned i = 0; i < N1; i++)       w1[A1W'(i)] <= '0;
            for (int unsigned i = 0; i < N2; i++)       w2[A2W'(i)] <= '0;
            for (int unsigned i = 0; i < HIDDEN1; i++)  hid[HW'(i)] <= '0;
            for (int unsigned i = 0; i < OUT_SIZE; i++) ov[OW'(i)]  <= '0;
        end else begin
            if (wr_ok) begin
                if (bus.wr_layer) w2[A2W'(bus.wr_addr)] <= bus.wr_data;
                else              w1[A1W'(bus.wr_addr)] <= bus.wr_data;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int unsigned i = 0; i < IN_SIZE; i++) x[XW'(i)] <= bus.in_vec[i];
                        r          <= '0;
                        c          <= '0;
                        pend       <= wr_ok;
                        pend_layer <= bus.wr_layer;
                        pend_addr  <= bus.wr_addr;
                        pend_old   <= bus.wr_layer ? w2[A2W'(bus.wr_addr)] : w1[A1W'(bus.wr_addr)];
                        state      <= L1;
                    end
                end
                L1: begin
                    if (c == C1_LAST) begin
                        hid[HW'(r)] <= WIDTH'(relu(RQ_W'(mac_q)));
                        c           <= '0;
                        if (r == R1_LAST) begin
                            r     <= '0;
                            state <= L2;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                L2: begin
                    if (c == C2_LAST) begin
                        ov[OW'(r)] <= mac_q;
                        // Strict greater-than keeps the lowest index on ties.
                        if ((r == '0) || (mac_q > vmax)) begin
                            vmax <= mac_q;
                            cls  <= CLS_W'(r);
                        end
                        c <= '0;
                        if (r == R2_LAST) begin
                            r     <= '0;
                            state <= DONE;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = mac_busy;
    assign bus.out_class = cls;

    always_comb begin
        bus.out_vec = '0;
        for (int unsigned i = 0; i < OUT_SIZE; i++) bus.out_vec[i] = ov[OW'(i)];
    end

endmodule

// File: tb/tb_nn_seq_mlp2.sv
// Scoreboard bench for nn_seq_mlp2 at default parameters (Q4.12, 1.0 = 4096).
// Expected overflow results follow NN_SAT_EN when it is defined for the build.
module tb_nn_seq_mlp2;

    localparam int unsigned IN_SIZE  = 4;
    localparam int unsigned HIDDEN1  = 3;
    localparam int unsigned OUT_SIZE = 2;
    localparam int unsigned WIDTH    = 16;
    localparam int unsigned FRAC     = 12;
    localparam int unsigned AW       = 4;

`ifdef NN_SAT_EN
    localparam int OVF = 32767;
`else
    localparam int OVF = 16384;
`endif

    typedef struct {
        int o0;
        int o1;
        int cls;
        bit lat;
        int t0;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    exp_t sbq[$];

    int basic_w1[12] = '{4096, 0, 0, 0,  0, 4096, 0, 0,  0, 0, -4096, 0};
    int basic_w2[6]  = '{4096, 0, 0,  0, 4096, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nn_seq_mlp2_if #(.IN_SIZE(IN_SIZE), .HIDDEN1(HIDDEN1), .OUT_SIZE(OUT_SIZE), .WIDTH(WIDTH)) bus ();

    nn_seq_mlp2 #(
        .IN_SIZE (IN_SIZE),
        .HIDDEN1 (HIDDEN1),
        .OUT_SIZE(OUT_SIZE),
        .WIDTH   (WIDTH),
        .FRAC    (FRAC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input bit layer, input int addr, input int data);
        @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_layer = layer;
        bus.wr_addr  = AW'(addr);
        bus.wr_data  = 16'(data);
        @(negedge clk);
        bus.wr_en    = 1'b0;
    endtask

    task automatic load_w1(input int v[12]);
        for (int i = 0; i < 12; i++) wr(1'b0, i, v[i]);
    endtask

    task automatic load_w2(input int v[6]);
        for (int i = 0; i < 6; i++) wr(1'b1, i, v[i]);
    endtask

    // Waits for in_ready, presents one vector (optionally with a W1 write on the
    // same edge) and queues the expected result for the monitor.
    task automatic run(input int x0, input int x1, input int x2, input int x3,
                       input bit push, input int e0, input int e1, input int ecls, input bit lat,
                       input bit do_wr, input int wa, input int wd, output int t0);
        int n;
        n  = 0;
        t0 = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", bus.in_ready, 1);
            return;
        end
        bus.in_vec[0] = 16'(x0);
        bus.in_vec[1] = 16'(x1);
        bus.in_vec[2] = 16'(x2);
        bus.in_vec[3] = 16'(x3);
        bus.in_valid  = 1'b1;
        if (do_wr) begin
            bus.wr_en    = 1'b1;
            bus.wr_layer = 1'b0;
            bus.wr_addr  = AW'(wa);
            bus.wr_data  = 16'(wd);
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        if (push) sbq.push_back('{o0: e0, o1: e1, cls: ecls, lat: lat, t0: t0});
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.wr_en    = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_outstanding", sbq.size(), 0);
            sbq.delete();
        end
        @(negedge clk);
        #2;
    endtask

    // Monitor: a result is consumed on the edge after out_valid && out_ready is seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_vec0", $signed(bus.out_vec[0]), e.o0);
                    chk("out_vec1", $signed(bus.out_vec[1]), e.o1);
                    chk("out_class", bus.out_class, e.cls);
                    if (e.lat) chk("latency", cyc + 1 - e.t0, 19);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got %0d vectors, expected completion", nvec);
        $fatal(1);
    end

    initial begin
        int ta;
        int tb;
        int td;
        int n;
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_layer = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_vec0", $signed(bus.out_vec[0]), 0);
        chk("rst_out_class", bus.out_class, 0);

        // Basic inference, then back-to-back for throughput.
        load_w1(basic_w1);
        load_w2(basic_w2);
        run(4096, 2048, 1024, 0, 1, 4096, 2048, 0, 1, 0, 0, 0, ta);
        run(4096, 2048, 1024, 0, 1, 4096, 2048, 0, 1, 0, 0, 0, tb);
        chk("throughput", tb - ta, 20);
        drain();

        // Second logit wins.
        run(1024, 8192, 0, 0, 1, 1024, 8192, 1, 0, 0, 0, 0, td);
        drain();

        // Hidden[2] must be ReLU-clipped (pre-activation -1024).
        wr(1'b1, 4, 0);
        wr(1'b1, 5, 4096);
        run(4096, 2048, 1024, 0, 1, 4096, 0, 0, 0, 0, 0, 0, td);
        drain();

        // Requant floors toward -inf: -2048 >>> 12 = -1.
        wr(1'b1, 0, -1);
        wr(1'b1, 5, 0);
        run(2048, 0, 0, 0, 1, -1, 0, 1, 0, 0, 0, 0, td);
        drain();

        // Tie: identical W2 rows give class 0.
        wr(1'b1, 0, 0);
        wr(1'b1, 1, 4096);
        wr(1'b1, 4, 4096);
        run(4096, 2048, 1024, 0, 1, 2048, 2048, 0, 0, 0, 0, 0, td);
        drain();

        // Negative logits.
        wr(1'b1, 0, -4096);
        wr(1'b1, 1, 0);
        wr(1'b1, 4, -4096);
        run(4096, 2048, 1024, 0, 1, -4096, -2048, 1, 0, 0, 0, 0, td);
        drain();
        load_w2(basic_w2);

        // Write during L1 is dropped.
        wr(1'b0, 0, 8192);
        run(4096, 2048, 1024, 0, 1, 8192, 2048, 0, 0, 0, 0, 0, td);
        repeat (2) @(negedge clk);
        bus.wr_en    = 1'b1;
        bus.wr_layer = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = 16'(4096);
        #1;
        chk("busy_during_l1", bus.busy, 1);
        @(negedge clk);
        bus.wr_en = 1'b0;
        drain();
        run(4096, 2048, 1024, 0, 1, 8192, 2048, 0, 0, 0, 0, 0, td);
        drain();

        // Write on the accept edge: this run uses old W1[0], the next the new one.
        run(4096, 2048, 1024, 0, 1, 8192, 2048, 0, 0, 1, 0, 4096, td);
        drain();
        run(4096, 2048, 1024, 0, 1, 4096, 2048, 0, 0, 0, 0, 0, td);
        drain();

        // Backpressure: held 10 cycles in DONE, in_valid pulses ignored.
        @(negedge clk);
        bus.out_ready = 1'b0;
        run(1024, 8192, 0, 0, 1, 1024, 8192, 1, 0, 0, 0, 0, td);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid  = (k % 3 == 0);
            bus.in_vec[0] = 16'(4096);
            #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_vec0", $signed(bus.out_vec[0]), 1024);
            chk("bp_out_vec1", $signed(bus.out_vec[1]), 8192);
            chk("bp_out_class", bus.out_class, 1);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_idle_in_ready", bus.in_ready, 1);
        chk("bp_idle_out_valid", bus.out_valid, 0);
        drain();

        // Overflow: hidden accumulates 4 * 7.0 * 7.0 = 196.0.
        for (int i = 0; i < 12; i++) wr(1'b0, i, 28672);
        run(28672, 28672, 28672, 28672, 1, OVF, OVF, 0, 0, 0, 0, 0, td);
        drain();

        // Reset mid-L1 clears everything including weights.
        run(4096, 2048, 1024, 0, 0, 0, 0, 0, 0, 0, 0, 0, td);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_out_vec1", $signed(bus.out_vec[1]), 0);
        run(4096, 2048, 1024, 0, 1, 0, 0, 0, 0, 0, 0, 0, td);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
